// File: rtl/game_pkg.sv
// Shared game constants: state codes, screen/sprite geometry, parking position of dead objects
// and the bullet-slot record used by the player-bullet pool.
`timescale 1ns/1ps
package game_pkg;

  typedef enum logic [2:0] {
    GAME_IDLE    = 3'd0,
    GAME_PLAYING = 3'd1,
    GAME_VICTORY = 3'd2,
    GAME_DEFEAT  = 3'd3,
    GAME_ERROR   = 3'd4
  } game_state_e;

  localparam int MONITOR_WIDTH  = 640;
  localparam int MONITOR_HEIGHT = 480;
  localparam int PLAYER_WIDTH   = 24;
  localparam int BULLET_WIDTH   = 4;
  localparam int BULLET_HEIGHT  = 16;

  localparam int N_SLOTS    = 16;
  localparam int SLOT_IDX_W = 4;

  // Off-screen parking spot for dead objects; the renderer never clips against it.
  localparam logic [9:0] NONE_X = 10'd720;
  localparam logic [8:0] NONE_Y = 9'd500;

  typedef struct packed {
    logic       alive;
    logic [9:0] x;
    logic [8:0] y;
  } slot_t;

  localparam slot_t SLOT_NONE = '{alive: 1'b0, x: NONE_X, y: NONE_Y};

endpackage

// File: rtl/free_slot_pe.sv
// Lowest-zero priority encoder over the 16-bit alive mask: reports whether any slot is free
// and the index of the lowest free one.
`timescale 1ns/1ps
module free_slot_pe
  import game_pkg::*;
(
  input  logic [N_SLOTS-1:0]    i_mask,
  output logic                  o_found,
  output logic [SLOT_IDX_W-1:0] o_idx
);

  // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    // Scan downward so the last hit, i.e. the lowest free index, is the one that sticks.
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (!i_mask[i]) begin
        o_found = 1'b1;
        o_idx   = i[SLOT_IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/player_bullet_ctrl.sv
// Player-bullet pool: grants fire requests to the lowest free slot, moves live bullets up on each
// frame_tick and retires them on screen exit or hit. Define PLAYER_BULLET_AUTOFIRE_EN for auto-fire.
`timescale 1ns/1ps
module player_bullet_ctrl
  import game_pkg::*;
#(
  parameter logic [8:0] BULLET_SPEED = 9'd4,
  parameter logic [3:0] COOLDOWN     = 4'd8,
  parameter logic [9:0] X_OFFSET     = 10'd10,
  parameter logic [8:0] SPAWN_DY     = 9'd16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            game_state,
  input  logic                  frame_tick,
  input  logic                  fire_req,
  input  logic [9:0]            player_x,
  input  logic [8:0]            player_y,
  output logic                  fire_ack,
  input  logic                  hit_valid,
  input  logic [SLOT_IDX_W-1:0] hit_idx,
  input  logic [SLOT_IDX_W-1:0] rd_idx,
  output logic [9:0]            rd_x,
  output logic [8:0]            rd_y,
  output logic                  rd_alive,
  output logic [N_SLOTS-1:0]    alive_mask,
  output logic [4:0]            active_count,
  output logic                  pool_full
);

  slot_t                 r_slot [N_SLOTS];
  slot_t                 w_slot_nxt [N_SLOTS];
  logic [3:0]            r_cooldown;
  logic [3:0]            w_cooldown_nxt;
  logic                  r_fire_ack;
  logic [4:0]            r_active_count;
  logic [4:0]            w_count_nxt;
  logic [N_SLOTS-1:0]    w_alive_mask;
  logic                  w_playing;
  logic                  w_fire_qual;
  logic                  w_pe_found;
  logic [SLOT_IDX_W-1:0] w_pe_idx;
  logic                  w_grant;

  always_comb begin
    w_alive_mask = '0;
    for (int i = 0; i < N_SLOTS; i++) w_alive_mask[i] = r_slot[i].alive;
  end

  free_slot_pe u_free_slot_pe (
    .i_mask  (w_alive_mask),
    .o_found (w_pe_found),
    .o_idx   (w_pe_idx)
  );

`ifdef PLAYER_BULLET_AUTOFIRE_EN
  assign w_fire_qual = fire_req;
`else
  logic r_fire_req_d;

  always_ff @(posedge clk) begin
    if (rst) r_fire_req_d <= 1'b0;
    else     r_fire_req_d <= fire_req;
  end

  // One bullet per press; an edge that arrives during cooldown or a full pool is simply lost.
  assign w_fire_qual = fire_req & ~r_fire_req_d;
`endif

  assign w_playing = (game_state == GAME_PLAYING);

  // Allocation looks only at the pre-cycle mask, so a slot freed this cycle is not reused until next.
  assign w_grant = w_playing & w_fire_qual & (r_cooldown == 4'd0) & w_pe_found &
                   (player_y >= SPAWN_DY);

  always_comb begin
    w_cooldown_nxt = r_cooldown;
    w_count_nxt    = '0;
    for (int i = 0; i < N_SLOTS; i++) w_slot_nxt[i] = r_slot[i];

    if (!w_playing) begin
      w_cooldown_nxt = '0;
      for (int i = 0; i < N_SLOTS; i++) w_slot_nxt[i] = SLOT_NONE;
    end else begin
      if (w_grant)                                w_cooldown_nxt = COOLDOWN;
      else if (frame_tick && r_cooldown != 4'd0)  w_cooldown_nxt = r_cooldown - 4'd1;

      // A hit beats movement; a freshly granted slot was dead, so it skips this tick's move.
      for (int i = 0; i < N_SLOTS; i++) begin
        if (r_slot[i].alive) begin
          if (hit_valid && hit_idx == i[SLOT_IDX_W-1:0]) begin
            w_slot_nxt[i] = SLOT_NONE;
          end else if (frame_tick) begin
            if (r_slot[i].y >= BULLET_SPEED) w_slot_nxt[i].y = r_slot[i].y - BULLET_SPEED;
            else                             w_slot_nxt[i] = SLOT_NONE;
          end
        end else if (w_grant && w_pe_idx == i[SLOT_IDX_W-1:0]) begin
          w_slot_nxt[i] = '{alive: 1'b1, x: player_x + X_OFFSET, y: player_y - SPAWN_DY};
        end
      end
    end

    for (int i = 0; i < N_SLOTS; i++) w_count_nxt = w_count_nxt + {4'd0, w_slot_nxt[i].alive};
  end

  // NOTE: sequential state uses non-blocking assignments only; the slot file is small enough that
  // resetting every entry (unlike a RAM) is cheap and keeps dead slots parked from the first cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_SLOTS; i++) r_slot[i] <= SLOT_NONE;
      r_cooldown     <= '0;
      r_fire_ack     <= 1'b0;
      r_active_count <= '0;
    end else begin
      for (int i = 0; i < N_SLOTS; i++) r_slot[i] <= w_slot_nxt[i];
      r_cooldown     <= w_cooldown_nxt;
      r_fire_ack     <= w_grant;
      r_active_count <= w_count_nxt;
    end
  end

  assign fire_ack     = r_fire_ack;
  assign alive_mask   = w_alive_mask;
  assign active_count = r_active_count;
  assign pool_full    = &w_alive_mask;
  assign rd_x         = r_slot[rd_idx].x;
  assign rd_y         = r_slot[rd_idx].y;
  assign rd_alive     = r_slot[rd_idx].alive;

endmodule

// File: tb/tb_player_bullet_ctrl.sv
// Self-checking bench for player_bullet_ctrl: directed scenarios followed by random traffic, all
// compared every cycle against a slot-pool model kept here.
`timescale 1ns/1ps
module tb_player_bullet_ctrl;
  import game_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  game_state;
  logic        frame_tick;
  logic        fire_req;
  logic [9:0]  player_x;
  logic [8:0]  player_y;
  logic        fire_ack;
  logic        hit_valid;
  logic [3:0]  hit_idx;
  logic [3:0]  rd_idx;
  logic [9:0]  rd_x;
  logic [8:0]  rd_y;
  logic        rd_alive;
  logic [15:0] alive_mask;
  logic [4:0]  active_count;
  logic        pool_full;

  always #20 clk = ~clk;

  player_bullet_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .game_state   (game_state),
    .frame_tick   (frame_tick),
    .fire_req     (fire_req),
    .player_x     (player_x),
    .player_y     (player_y),
    .fire_ack     (fire_ack),
    .hit_valid    (hit_valid),
    .hit_idx      (hit_idx),
    .rd_idx       (rd_idx),
    .rd_x         (rd_x),
    .rd_y         (rd_y),
    .rd_alive     (rd_alive),
    .alive_mask   (alive_mask),
    .active_count (active_count),
    .pool_full    (pool_full)
  );

  // Reference pool: plain arrays and integer arithmetic.
  bit m_alive [16];
  int m_x     [16];
  int m_y     [16];
  int m_cool;
  bit m_prev;
  bit m_ack;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void park(input int i);
    m_alive[i] = 1'b0;
    m_x[i]     = 720;
    m_y[i]     = 500;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) park(i);
    m_cool = 0;
    m_prev = 1'b0;
    m_ack  = 1'b0;
  endfunction

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < 16; i++) c += int'(m_alive[i]);
    return c;
  endfunction

  function automatic logic [15:0] model_mask();
    logic [15:0] m = '0;
    for (int i = 0; i < 16; i++) m[i] = m_alive[i];
    return m;
  endfunction

  // Applies one clock of the rules to the model using the inputs currently driven.
  function automatic void model_step();
    bit fire_q;
    bit grant;
    int free_slot;
    if (rst) begin
      model_reset();
      return;
    end
`ifdef PLAYER_BULLET_AUTOFIRE_EN
    fire_q = fire_req;
`else
    fire_q = fire_req && !m_prev;
`endif
    m_prev = fire_req;
    if (game_state != GAME_PLAYING) begin
      for (int i = 0; i < 16; i++) park(i);
      m_cool = 0;
      m_ack  = 1'b0;
      return;
    end
    free_slot = -1;
    for (int i = 15; i >= 0; i--) if (!m_alive[i]) free_slot = i;
    grant = fire_q && (m_cool == 0) && (free_slot >= 0) && (int'(player_y) >= 16);
    for (int i = 0; i < 16; i++) begin
      if (m_alive[i]) begin
        if (hit_valid && int'(hit_idx) == i) park(i);
        else if (frame_tick) begin
          if (m_y[i] >= 4) m_y[i] -= 4;
          else park(i);
        end
      end
    end
    if (grant) begin
      m_alive[free_slot] = 1'b1;
      m_x[free_slot]     = (int'(player_x) + 10) % 1024;
      m_y[free_slot]     = int'(player_y) - 16;
    end
    if (grant)                       m_cool = 8;
    else if (frame_tick && m_cool > 0) m_cool = m_cool - 1;
    m_ack = grant;
  endfunction

  // One clock: update the model, take the edge, then compare flags and every slot via the read port.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check("fire_ack", fire_ack, m_ack);
    check("alive_mask", alive_mask, model_mask());
    check("active_count", active_count, model_count());
    check("pool_full", pool_full, model_mask() == 16'hFFFF);
    for (int i = 0; i < 16; i++) begin
      rd_idx = i[3:0];
      #1;
      check($sformatf("rd_alive[%0d]", i), rd_alive, m_alive[i]);
      check($sformatf("rd_x[%0d]", i), rd_x, m_x[i]);
      check($sformatf("rd_y[%0d]", i), rd_y, m_y[i]);
    end
  endtask

  task automatic press();
    fire_req = 1'b1;
    cycle();
    fire_req = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int k = 0; k < n; k++) begin
      frame_tick = 1'b1;
      cycle();
      frame_tick = 1'b0;
      cycle();
    end
  endtask

  task automatic peek(input int idx);
    rd_idx = idx[3:0];
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    game_state = GAME_PLAYING;
  endtask

  initial begin
    int acks;
    int tcount;
    int g_pre [2];
    bit g_tick [2];
    int prev_y4;
    int r;

    rst = 1'b1; game_state = GAME_IDLE; frame_tick = 1'b0; fire_req = 1'b0;
    player_x = 10'd302; player_y = 9'd372; hit_valid = 1'b0; hit_idx = '0; rd_idx = '0;
    model_reset();

    // Reset state.
    cycle();
    check("reset_ack", fire_ack, 0);
    check("reset_count", active_count, 0);
    check("reset_full", pool_full, 0);

    // 1: first shot spawns at (312,356) in slot 0.
    rst = 1'b0; game_state = GAME_PLAYING;
    cycle();
    press();
    check("t1_ack", fire_ack, 1);
    check("t1_count", active_count, 1);
    peek(0);
    check("t1_x", rd_x, 312);
    check("t1_y", rd_y, 356);

    // 2: held button over several frames.
    do_reset();
    acks = 0; tcount = 0;
    fire_req = 1'b1;
    for (int c = 0; c < 24; c++) begin
      int pre;
      frame_tick = (c % 2 == 0);
      pre = tcount;
      cycle();
      if (frame_tick) tcount++;
      if (fire_ack === 1'b1) begin
        if (acks < 2) begin
          g_pre[acks]  = pre;
          g_tick[acks] = frame_tick;
        end
        acks++;
      end
    end
    fire_req = 1'b0; frame_tick = 1'b0;
    cycle();
`ifdef PLAYER_BULLET_AUTOFIRE_EN
    check("t2_grants", acks, 2);
    if (acks >= 2) check("t2_ticks_between", g_pre[1] - g_pre[0] - int'(g_tick[0]), 8);
`else
    check("t2_grants", acks, 1);
`endif

    // 3: shallow spawn rules, then a bullet leaving the top of the screen.
    do_reset();
    player_y = 9'd15;
    press();
    check("t3_low_y_no_ack", fire_ack, 0);
    cycle();
    player_y = 9'd22;
    press();
    check("t3_ack_after_suppressed", fire_ack, 1);
    peek(0);
    check("t3_spawn_y", rd_y, 6);
    frame_tick = 1'b1; cycle(); frame_tick = 1'b0;
    peek(0);
    check("t3_y_after_tick", rd_y, 2);
    frame_tick = 1'b1; cycle(); frame_tick = 1'b0;
    peek(0);
    check("t3_retired_alive", rd_alive, 0);
    check("t3_retired_x", rd_x, 720);
    check("t3_retired_y", rd_y, 500);
    check("t3_mask_bit0", alive_mask[0], 0);

    // 4: fill the pool, refused shot, then a hit-freed slot gets reused.
    do_reset();
    player_x = 10'd100; player_y = 9'd511;
    for (int k = 0; k < 16; k++) begin
      press();
      check($sformatf("t4_fill_ack%0d", k), fire_ack, 1);
      if (k < 15) frames(8);
    end
    check("t4_full", pool_full, 1);
    check("t4_count16", active_count, 16);
    press();
    check("t4_full_no_ack", fire_ack, 0);
    for (int k = 0; k < 5; k++) begin
      frames(8);
      press();
      check($sformatf("t4_refill_ack%0d", k), fire_ack, 1);
    end
    hit_valid = 1'b1; hit_idx = 4'd5;
    cycle();
    hit_valid = 1'b0;
    check("t4_hit5_mask", alive_mask[5], 0);
    frames(8);
    press();
    check("t4_regrant_ack", fire_ack, 1);
    peek(5);
    check("t4_slot5_alive", rd_alive, 1);
    check("t4_slot5_y", rd_y, 495);

    // 5: hit and frame_tick on the same cycle.
    prev_y4 = m_y[4];
    hit_valid = 1'b1; hit_idx = 4'd3; frame_tick = 1'b1;
    cycle();
    hit_valid = 1'b0; frame_tick = 1'b0;
    peek(3);
    check("t5_slot3_alive", rd_alive, 0);
    check("t5_slot3_y", rd_y, 500);
    peek(4);
    check("t5_slot4_moved", rd_y, prev_y4 - 4);

    // 6: leaving PLAYING clears the pool; reset overrides a shot in flight.
    for (int i = 0; i < 16; i++) begin
      if (model_count() > 7 && m_alive[i]) begin
        hit_valid = 1'b1; hit_idx = i[3:0];
        cycle();
      end
    end
    hit_valid = 1'b0;
    cycle();
    check("t6_count7", active_count, 7);
    game_state = GAME_DEFEAT;
    cycle();
    check("t6_cleared_mask", alive_mask, 0);
    check("t6_cleared_count", active_count, 0);
    game_state = GAME_PLAYING;
    cycle();
    fire_req = 1'b1; rst = 1'b1;
    cycle();
    check("t6_rst_with_fire_ack", fire_ack, 0);
    rst = 1'b0; fire_req = 1'b0;
    cycle();
    press();
    check("t6_ack_before_rst", fire_ack, 1);
    rst = 1'b1;
    cycle();
    check("t6_rst_clears_ack", fire_ack, 0);
    check("t6_rst_clears_mask", alive_mask, 0);
    rst = 1'b0;

    // Random traffic.
    for (int c = 0; c < 600; c++) begin
      r = $urandom_range(0, 99);
      rst = (r == 0);
      if (r == 1 || r == 2) game_state = 3'($urandom_range(0, 4));
      else if (game_state != GAME_PLAYING && r < 25) game_state = GAME_PLAYING;
      fire_req   = ($urandom_range(0, 1) == 1);
      frame_tick = ($urandom_range(0, 9) < 3);
      hit_valid  = ($urandom_range(0, 9) < 3);
      hit_idx    = 4'($urandom_range(0, 15));
      player_x   = 10'($urandom_range(0, 1023));
      player_y   = 9'($urandom_range(0, 511));
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
